// File: rtl/rns_mod_addsub_front.sv
// rns_mod_addsub_front: two-stage front end of an RNS modular add/sub, producing
// both the raw and modulus-corrected candidates plus the select bit for a 2:1 stage.
module rns_mod_addsub_front (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m_load,
    input  logic [3:0] m_in,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       op_sub,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] num,
    output logic [3:0] comp,
    output logic       s0,
    output logic       err
);
    logic [3:0] m, a1, b1, m1, diff, num_d, comp_d;
    logic [4:0] sum;
    logic       v1, op1, err1, advance, s0_d;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // (sum - m) mod 16 only needs the low nibble of sum
    always_comb begin
        sum    = {1'b0, a1} + {1'b0, b1};
        diff   = a1 - b1;
        num_d  = op1 ? diff : sum[3:0];
        comp_d = op1 ? diff + m1 : sum[3:0] - m1;
        s0_d   = op1 ? (a1 < b1) : (sum >= {1'b0, m1});
    end

    // modulus changes only when nothing is in flight or arriving
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            m <= 4'd15;
        else if (m_load && !in_valid && !v1 && !out_valid && m_in >= 4'd2)
            m <= m_in;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            v1   <= 1'b0;
            a1   <= 4'd0;
            b1   <= 4'd0;
            m1   <= 4'd15;
            op1  <= 1'b0;
            err1 <= 1'b0;
        end else if (advance) begin
            v1 <= in_valid;
            if (in_valid) begin
                a1   <= a;
                b1   <= b;
                m1   <= m;
                op1  <= op_sub;
                err1 <= (a >= m) || (b >= m);
            end
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_valid <= 1'b0;
            num       <= 4'd0;
            comp      <= 4'd0;
            s0        <= 1'b0;
            err       <= 1'b0;
        end else if (advance) begin
            out_valid <= v1;
            if (v1) begin
                num  <= num_d;
                comp <= comp_d;
                s0   <= s0_d;
                err  <= err1;
            end
        end
endmodule

// File: tb/tb_rns_mod_addsub_front.sv
// tb_rns_mod_addsub_front: directed vector table, hand sequences for stall/reset/load
// corners, and random traffic checked against a queue-based arithmetic model.
module tb_rns_mod_addsub_front;
    logic       clk, rst_n, m_load, in_valid, in_ready, op_sub, out_valid, out_ready, s0, err;
    logic [3:0] m_in, a, b, num, comp;

    rns_mod_addsub_front dut (
        .clk(clk), .rst_n(rst_n), .m_load(m_load), .m_in(m_in),
        .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .num(num), .comp(comp), .s0(s0), .err(err)
    );

    typedef struct { logic [3:0] num, comp; logic s0, err; } exp_t;
    typedef struct { int m, op, a, b, num, comp, s0, err; } vec_t;

    int   vecs = 0, errs = 0;
    exp_t q[$];
    int   m_model = 15;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input int op, input int x, input int y, input int mm);
        exp_t e;
        int   s;
        if (op == 0) begin
            s      = x + y;
            e.num  = 4'(s % 16);
            e.comp = 4'((s - mm + 32) % 16);
            e.s0   = s >= mm;
        end else begin
            e.num  = 4'((x - y + 16) % 16);
            e.comp = 4'((x - y + mm + 32) % 16);
            e.s0   = x < y;
        end
        e.err = (x >= mm) || (y >= mm);
        return e;
    endfunction

    // scoreboard: sampled on the falling edge, mid-cycle
    initial begin
        logic       hold;
        logic [3:0] h_num, h_comp;
        logic       h_s0, h_err;
        bit         empty;
        exp_t       e;
        hold = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                m_model = 15;
                hold = 0;
                chk("rst_out_valid", int'(out_valid), 0);
                chk("rst_in_ready", int'(in_ready), 1);
            end else begin
                empty = q.size() == 0;
                chk("in_ready", int'(in_ready), int'(!out_valid || out_ready));
                if (hold) begin
                    chk("hold_valid", int'(out_valid), 1);
                    chk("hold_num", int'(num), int'(h_num));
                    chk("hold_comp", int'(comp), int'(h_comp));
                    chk("hold_s0", int'(s0), int'(h_s0));
                    chk("hold_err", int'(err), int'(h_err));
                end
                if (out_valid && out_ready) begin
                    if (empty) begin
                        vecs++;
                        errs++;
                        $display("FAIL unexpected_out: output transfer with nothing outstanding at %0t", $time);
                    end else begin
                        e = q.pop_front();
                        chk("out_num", int'(num), int'(e.num));
                        chk("out_comp", int'(comp), int'(e.comp));
                        chk("out_s0", int'(s0), int'(e.s0));
                        chk("out_err", int'(err), int'(e.err));
                    end
                end
                hold = out_valid && !out_ready;
                h_num = num; h_comp = comp; h_s0 = s0; h_err = err;
                if (in_valid && in_ready)
                    q.push_back(model(int'(op_sub), int'(a), int'(b), m_model));
                if (m_load && !in_valid && empty && m_in >= 4'd2)
                    m_model = int'(m_in);
            end
        end
    end

    task automatic load(input int v);
        m_in = 4'(v); m_load = 1;
        @(posedge clk); #1;
        m_load = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 0; m_load = 0; out_ready = 1;
        @(negedge clk);
        while ((q.size() != 0 || out_valid) && n < 20) begin
            @(negedge clk);
            n++;
        end
        vecs++;
        if (q.size() != 0 || out_valid) begin
            errs++;
            $display("FAIL drain: %0d transactions still outstanding", q.size());
        end
        @(posedge clk); #1;
    endtask

    // single isolated transaction from idle, exact latency checked
    task automatic send_check(input int op, input int x, input int y,
                              input int en, input int ec, input int es, input int ee);
        op_sub = op[0]; a = 4'(x); b = 4'(y); in_valid = 1; out_ready = 1;
        @(negedge clk);
        chk("acc_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        chk("lat_early", int'(out_valid), 0);
        @(negedge clk);
        chk("lat_valid", int'(out_valid), 1);
        chk("vec_num", int'(num), en);
        chk("vec_comp", int'(comp), ec);
        chk("vec_s0", int'(s0), es);
        chk("vec_err", int'(err), ee);
        @(posedge clk); #1;
    endtask

    vec_t tab[12];

    initial begin
        int cur_m;
        tab[0]  = '{15, 0,  9,  8,  1,  2, 1, 0};
        tab[1]  = '{15, 0,  3,  4,  7,  8, 0, 0};
        tab[2]  = '{15, 1,  3,  5, 14, 13, 1, 0};
        tab[3]  = '{15, 0,  0,  0,  0,  1, 0, 0};
        tab[4]  = '{15, 0,  7,  8, 15,  0, 1, 0};
        tab[5]  = '{15, 1,  5,  5,  0, 15, 0, 0};
        tab[6]  = '{15, 0, 15, 15, 14, 15, 1, 1};
        tab[7]  = '{15, 1,  0, 14,  2,  1, 1, 0};
        tab[8]  = '{15, 0, 14,  0, 14, 15, 0, 0};
        tab[9]  = '{11, 0,  6,  7, 13,  2, 1, 0};
        tab[10] = '{11, 0, 12,  0, 12,  1, 1, 1};
        tab[11] = '{11, 1,  2,  9,  9,  4, 1, 0};

        rst_n = 0; m_load = 0; m_in = 0; in_valid = 0; op_sub = 0; a = 0; b = 0; out_ready = 1;
        #3;
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_num", int'(num), 0);
        chk("reset_comp", int'(comp), 0);
        chk("reset_s0", int'(s0), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1;
        @(posedge clk); #1;

        cur_m = 15;
        for (int i = 0; i < 12; i++) begin
            if (tab[i].m != cur_m) begin
                load(tab[i].m);
                cur_m = tab[i].m;
            end
            send_check(tab[i].op, tab[i].a, tab[i].b, tab[i].num, tab[i].comp, tab[i].s0, tab[i].err);
        end

        // reset with two transactions in flight, modulus currently 11
        out_ready = 0; op_sub = 0; a = 9; b = 8; in_valid = 1;
        @(posedge clk); #1;
        a = 3; b = 4;
        @(posedge clk); #1;
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_num", int'(num), 0);
        chk("mid_rst_comp", int'(comp), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1; out_ready = 1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_valid", int'(out_valid), 0);
        end
        @(posedge clk); #1;
        send_check(0, 6, 7, 13, 14, 0, 0);

        // modulus load attempts while busy, then with an illegal value
        op_sub = 0; a = 1; b = 1; in_valid = 1; m_in = 5; m_load = 1;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_load = 0;
        drain();
        load(1);
        send_check(0, 6, 7, 13, 14, 0, 0);

        // back-to-back add then sub
        out_ready = 1; op_sub = 0; a = 3; b = 4; in_valid = 1;
        @(posedge clk); #1;
        op_sub = 1; a = 3; b = 5;
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        chk("b2b_valid0", int'(out_valid), 1);
        chk("b2b_num0", int'(num), 7);
        chk("b2b_comp0", int'(comp), 8);
        chk("b2b_s0_0", int'(s0), 0);
        @(negedge clk);
        chk("b2b_valid1", int'(out_valid), 1);
        chk("b2b_num1", int'(num), 14);
        chk("b2b_comp1", int'(comp), 13);
        chk("b2b_s0_1", int'(s0), 1);
        drain();

        // three requests against a stalled output
        out_ready = 0; op_sub = 0; a = 1; b = 2; in_valid = 1;
        @(posedge clk); #1;
        a = 3; b = 4;
        @(posedge clk); #1;
        op_sub = 1; a = 5; b = 1;
        repeat (4) begin
            @(negedge clk);
            chk("stall_in_ready", int'(in_ready), 0);
            chk("stall_num", int'(num), 3);
            @(posedge clk); #1;
        end
        out_ready = 1;
        @(negedge clk);
        chk("rel_num0", int'(num), 3);
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        chk("rel_num1", int'(num), 7);
        @(negedge clk);
        chk("rel_num2", int'(num), 4);
        drain();

        // random traffic with random modulus loads, including illegal values
        for (int i = 0; i < 600; i++) begin
            in_valid  = $urandom_range(0, 9) < ((i % 60) < 30 ? 8 : 2);
            op_sub    = 1'($urandom_range(0, 1));
            a         = 4'($urandom_range(0, 15));
            b         = 4'($urandom_range(0, 15));
            out_ready = $urandom_range(0, 3) != 0;
            m_load    = $urandom_range(0, 4) == 0;
            m_in      = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/rns_mod_addsub_front.md
RNS_MOD_ADDSUB_FRONT -- requirements
Module: rns_mod_addsub_front

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  clock; all state SHALL change on the rising edge only.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 m_load  input  1  modulus load strobe.
REQ-005 m_in  input  4  new modulus value; legal range 2..15.
REQ-006 in_valid  input  1  operand transfer request.
REQ-007 in_ready  output  1  block can accept operands this cycle.
REQ-008 op_sub  input  1  0 = a+b mod m; 1 = a-b mod m.
REQ-009 a, b  input  4 each  residue operands.
REQ-010 out_valid  output  1  num/comp/s0/err are valid.
REQ-011 out_ready  input  1  downstream 2:1 selector stage consumes output.
REQ-012 num  output  4  uncorrected candidate.
REQ-013 comp  output  4  modulus-corrected candidate.
REQ-014 s0  output  1  select: 1 = comp is the true residue, 0 = num.
REQ-015 err  output  1  an operand was >= m when accepted.

Function
REQ-016 An operand transfer SHALL occur on a rising edge where in_valid and in_ready are both 1.
REQ-017 An output transfer SHALL occur on a rising edge where out_valid and out_ready are both 1.
REQ-018 The pipeline SHALL have 2 stages (S1: operand/op/err capture; S2: num/comp/s0 registers).
REQ-019 Define advance = !out_valid | out_ready.
REQ-020 in_ready SHALL equal advance, combinationally.
REQ-021 Both stages SHALL shift only when advance=1; otherwise every stage, including the outputs, SHALL hold.
REQ-022 With out_ready held at 1, out_valid SHALL rise exactly 2 cycles after the accepting edge, giving throughput of 1 per cycle.
REQ-023 While out_valid=1 and out_ready=0, num, comp, s0 and err SHALL remain stable.
REQ-024 Add mode: s = a+b (5 bits); num = s[3:0]; comp = (s-m) mod 16; s0 = (s >= m).
REQ-025 Sub mode: num = (a-b) mod 16; comp = (a-b+m) mod 16; s0 = (a < b).
REQ-026 err SHALL be 1 if a >= m or b >= m at acceptance; the data SHALL still be passed and not dropped.
REQ-027 The modulus register SHALL load m_in on an edge with m_load=1 only while both stages are empty and in_valid=0; otherwise m_load SHALL be ignored.
REQ-028 A m_load with m_in < 2 SHALL be ignored.
REQ-029 Each transaction SHALL use the m value that was current at its acceptance, captured in S1.
REQ-030 Simultaneous output transfer and new acceptance in the same cycle SHALL lose no data and duplicate no data.

Reset
REQ-031 rst_n=0 SHALL immediately clear both stage valid bits, setting out_valid=0.
REQ-032 rst_n=0 SHALL immediately set num=0, comp=0, s0=0, err=0 and m=15.
REQ-033 While rst_n=0, in_ready SHALL be 1.
REQ-034 Assertion of rst_n mid-transaction SHALL discard all in-flight data; no output transfer SHALL follow after release.
REQ-035 Release of rst_n SHALL be synchronised externally; the block SHALL require no internal reset sequencing.

Verification
REQ-036 Scenario: m=15, add 9+8, out_ready=1 -> 2 cycles later num=1, comp=2, s0=1, err=0.
REQ-037 Scenario: m=15, add 3+4, then sub 3-5 back-to-back -> outputs on consecutive cycles: (num=7, comp=8, s0=0), then (num=14, comp=13, s0=1).
REQ-038 Scenario: idle, m_load with m_in=11, then add 6+7 -> num=13, comp=2, s0=1.
REQ-039 Scenario: m_load during traffic or with m_in=1 -> m unchanged.
REQ-040 Scenario: m=11, a=12, b=0 -> err=1 and the transaction completes.
REQ-041 Scenario: three transactions issued, out_ready=0 for 4 cycles -> in_ready=0 once full, outputs stable, all three delivered in order once out_ready=1.
REQ-042 Scenario: rst_n pulsed low with 2 transactions in flight -> out_valid=0 at once, m=15, no stale output after release.
